mod_issue_ctrl: RTL and testbench
=================================

Name: mod_issue_ctrl

Overview:
Request/response front-end for the 32-bit sequential modulo unit (Mod_32Bit).
- Accepts operand pairs over a valid/ready handshake and drives the unit's start/a/b inputs.
- Waits for the unit's done, then captures the result and returns it over a valid/ready response channel.
- Short-circuits divide-by-zero and enforces a completion timeout, so the ALU top level never hangs on the multi-cycle unit.

Parameters:
- WIDTH, 32, operand/result width; must match the modulo unit.
- TIMEOUT_CYCLES, 1024, max cycles in WAIT before abort; must be >= 2.
- CNT_W, 11, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low (0 = reset)
- req_valid  input  1  request operands valid
- req_ready  output  1  block can accept a request
- req_a  input  WIDTH  dividend
- req_b  input  WIDTH  divisor
- mod_start  output  1  one-cycle start pulse to modulo unit
- mod_a  output  WIDTH  dividend to modulo unit, held stable
- mod_b  output  WIDTH  divisor to modulo unit, held stable
- mod_result  input  WIDTH  modulo unit result
- mod_done  input  1  modulo unit completion flag
- rsp_valid  output  1  response valid
- rsp_ready  input  1  consumer accepts response
- rsp_result  output  WIDTH  a mod b, or 0 on error
- rsp_err  output  1  1 = divide-by-zero or timeout
- rsp_timeout  output  1  1 = error cause is timeout (valid with rsp_err)

Behaviour:
- Reset (rst==0 at clk edge):
  - state=IDLE.
  - req_ready=1; mod_start, rsp_valid, rsp_err, rsp_timeout = 0.
  - mod_a, mod_b, rsp_result = 0; timeout counter = 0.
  - Reset mid-operation aborts with no response; the modulo unit shares rst.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - req_ready=1 only in IDLE.
  - On req_valid & req_ready: latch req_a/req_b into mod_a/mod_b.
  - If req_b==0: next state RESP with rsp_result=0, rsp_err=1, rsp_timeout=0; mod_start is never raised.
  - Otherwise: next state ISSUE.
- ISSUE:
  - mod_start=1 for exactly this one cycle; clear the timeout counter.
  - Next state WAIT unconditionally.
  - mod_done seen in ISSUE is stale from a prior op and is ignored.
- WAIT:
  - mod_start=0; counter increments each cycle.
  - On the first cycle mod_done==1: rsp_result<=mod_result, rsp_err<=0, next state RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without mod_done: rsp_result<=0, rsp_err<=1, rsp_timeout<=1, next state RESP.
  - If mod_done and the timeout limit occur in the same cycle, mod_done wins (success).
- RESP:
  - rsp_valid=1. rsp_result/rsp_err/rsp_timeout stay stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid<=0, next state IDLE.
  - A new request can be accepted on the following cycle.
- mod_a/mod_b hold their latched values from acceptance until the next accepted request; they never change during WAIT.
- Latency:
  - Normal: accept -> ISSUE (1 cycle) -> WAIT (N cycles until done) -> rsp_valid on the cycle after done is sampled.
  - Divide-by-zero: rsp_valid 1 cycle after accept.
- Throughput: one outstanding operation; no queuing.

Decomposition:
- Shared package mod_pkg:
  - state enum (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3)
  - WIDTH default
  - error-cause encoding
- One natural sub-module: mod_timeout_cnt.
  - Clear/enable counter with a terminal-count flag at TIMEOUT_CYCLES-1.
  - Instanced once.
- Top-level integration instantiates mod_issue_ctrl beside Mod_32Bit: mod_start->start, mod_a->a, mod_b->b, result->mod_result, done->mod_done.

Test Plan:
- Basic: req a=17, b=5; model unit asserts done with result 2 after 4 cycles. Expect:
  - mod_start pulsed exactly once;
  - rsp_valid=1 with rsp_result=2, rsp_err=0 one cycle after done.
- Divide-by-zero: a=123, b=0. Expect:
  - no mod_start;
  - rsp_valid 1 cycle after accept, rsp_result=0, rsp_err=1, rsp_timeout=0.
- Backpressure: a=100, b=7; hold rsp_ready=0 for 5 cycles. Expect:
  - rsp_result=2 stable, req_ready=0 throughout;
  - IDLE the cycle after rsp_ready=1.
- Timeout: TIMEOUT_CYCLES=8; model unit never asserts done. Expect rsp_err=1, rsp_timeout=1, rsp_result=0 after 8 WAIT cycles.
- Stale done: hold mod_done=1 across the IDLE->ISSUE transition for a=9, b=4. Expect:
  - ISSUE ignores done;
  - result captured only from WAIT; rsp_result=1.
- Reset mid-op: assert rst=0 during WAIT. Expect:
  - next cycle state IDLE, req_ready=1, rsp_valid=0, mod_start=0;
  - no response emitted; a subsequent 10 mod 3 returns 1.

Source files
------------

// File: rtl/mod_pkg.sv
// Shared types for the modulo-unit issue controller: FSM states,
// error-cause encoding and the default datapath width.
package mod_pkg;

    localparam int MOD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_DIV0    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_cause_t;

    function automatic logic cause_is_err(input err_cause_t cause);
        return cause != ERR_NONE;
    endfunction

endpackage

// File: rtl/mod_timeout_cnt.sv
// Clear/enable cycle counter with a terminal-count flag at TIMEOUT_CYCLES-1.
module mod_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/mod_issue_ctrl.sv
// Request/response front-end for the sequential modulo unit: issues one
// operation at a time, short-circuits b==0 and aborts on a completion timeout.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid, once raised, holds with its payload stable until that transfer.
module mod_issue_ctrl
    import mod_pkg::*;
#(
    parameter int WIDTH          = MOD_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             mod_start,
    output logic [WIDTH-1:0] mod_a,
    output logic [WIDTH-1:0] mod_b,
    input  logic [WIDTH-1:0] mod_result,
    input  logic             mod_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,
    output logic             rsp_timeout,
    output state_t           fsm_state
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mod_a_d, mod_b_d, rsp_result_d;
    logic             rsp_err_d, rsp_timeout_d;
    logic             capture;
    err_cause_t       cause;
    logic             tc;

    mod_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timeout_cnt (
        .clk(clk),
        .rst(rst),
        .clr(state_q == ISSUE),
        .en (state_q == WAIT),
        .tc (tc)
    );

    always_comb begin
        state_d       = state_q;
        mod_a_d       = mod_a;
        mod_b_d       = mod_b;
        rsp_result_d  = rsp_result;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;
        capture       = 1'b0;
        cause         = ERR_NONE;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    mod_a_d = req_a;
                    mod_b_d = req_b;
                    if (req_b == '0) begin
                        state_d      = RESP;
                        rsp_result_d = '0;
                        cause        = ERR_DIV0;
                        capture      = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            // Any done seen here belongs to a previous operation.
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (mod_done) begin
                    state_d      = RESP;
                    rsp_result_d = mod_result;
                    cause        = ERR_NONE;
                    capture      = 1'b1;
                end else if (tc) begin
                    state_d      = RESP;
                    rsp_result_d = '0;
                    cause        = ERR_TIMEOUT;
                    capture      = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (capture) begin
            rsp_err_d     = cause_is_err(cause);
            rsp_timeout_d = (cause == ERR_TIMEOUT);
        end
    end

    // Handshake flags are registered from the next state so every output is a flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_ready   <= 1'b1;
            mod_start   <= 1'b0;
            mod_a       <= '0;
            mod_b       <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready   <= (state_d == IDLE);
            mod_start   <= (state_d == ISSUE);
            mod_a       <= mod_a_d;
            mod_b       <= mod_b_d;
            rsp_valid   <= (state_d == RESP);
            rsp_result  <= rsp_result_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_mod_issue_ctrl.sv
// Bench for mod_issue_ctrl with a behavioural modulo-unit model and a response scoreboard.
`timescale 1ns/1ps
module tb_mod_issue_ctrl;
    import mod_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_a, req_b;
    logic        mod_start;
    logic [31:0] mod_a, mod_b, mod_result;
    logic        mod_done;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_err, rsp_timeout;
    state_t      fsm_state;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    // expected {err, timeout, result}
    logic [33:0] exp_q[$];

    int          model_lat = 4;
    bit          model_never_done = 1'b0;
    bit          force_done = 1'b0;
    logic        m_busy, m_done;
    int          m_cnt;
    logic [31:0] m_res = 32'd0;

    mod_issue_ctrl #(
        .WIDTH(32),
        .TIMEOUT_CYCLES(8),
        .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mod_start(mod_start), .mod_a(mod_a), .mod_b(mod_b),
        .mod_result(mod_result), .mod_done(mod_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // behavioural modulo unit: done pulses model_lat cycles after start
    always @(posedge clk) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else if (mod_start) begin
            m_busy <= 1'b1;
            m_cnt  <= model_lat;
            m_done <= 1'b0;
        end else if (m_busy && !model_never_done) begin
            if (m_cnt <= 1) begin
                m_done <= 1'b1;
                m_res  <= mod_a % mod_b;
                m_busy <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else begin
            m_done <= 1'b0;
        end
    end
    assign mod_done   = m_done | force_done;
    assign mod_result = m_res;

    // scoreboard: compare each accepted response against the expected queue
    always @(negedge clk) begin
        logic [33:0] got, exp;
        if (rst && mod_start) start_cnt++;
        if (rst && rsp_valid && rsp_ready) begin
            got = {rsp_err, rsp_timeout, rsp_result};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got err=%0d to=%0d res=%0d, required no response",
                         rsp_err, rsp_timeout, rsp_result);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL rsp_scoreboard: got err=%0d to=%0d res=%0d, required err=%0d to=%0d res=%0d",
                             got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
                end
            end
        end
    end

    // driver tasks (all enter and leave at posedge + 1)
    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit push);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_wait: got req_ready=0 after %0d cycles, required 1", n);
            return;
        end
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        if (push) begin
            if (b == 32'd0)            exp_q.push_back({2'b10, 32'd0});
            else if (model_never_done) exp_q.push_back({2'b11, 32'd0});
            else                       exp_q.push_back({2'b00, a % b});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, mod_start, rsp_valid, rsp_err, rsp_timeout} !== 5'b10000 || fsm_state !== IDLE) begin
            errors++;
            $display("FAIL reset_flags: got rdy=%0d start=%0d vld=%0d err=%0d to=%0d st=%0d, required 1 0 0 0 0 0",
                     req_ready, mod_start, rsp_valid, rsp_err, rsp_timeout, fsm_state);
        end
        checks++;
        if (mod_a !== 32'd0 || mod_b !== 32'd0 || rsp_result !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got a=%0d b=%0d res=%0d, required 0 0 0", mod_a, mod_b, rsp_result);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int s0, done_cyc, rsp_cyc;
        logic [31:0] res;
        model_lat = 4;
        rsp_ready = 1'b1;
        s0 = start_cnt;
        done_cyc = -1;
        rsp_cyc = -1;
        res = 32'hffff_ffff;
        send(32'd17, 32'd5, 1'b1);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (mod_done && done_cyc < 0) done_cyc = cyc;
            if (rsp_valid) begin
                rsp_cyc = cyc;
                res = rsp_result;
                break;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done_cyc < 0 || rsp_cyc !== done_cyc + 1) begin
            errors++;
            $display("FAIL basic_latency: got done_cyc=%0d rsp_cyc=%0d, required rsp_cyc=done_cyc+1", done_cyc, rsp_cyc);
        end
        checks++;
        if (res !== 32'd2) begin
            errors++;
            $display("FAIL basic_result: got %0d, required 2", res);
        end
        wait_drain(20);
        checks++;
        if (start_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL basic_start_pulses: got %0d, required 1", start_cnt - s0);
        end
    endtask

    task automatic test_div0();
        int s0;
        rsp_ready = 1'b1;
        s0 = start_cnt;
        send(32'd123, 32'd0, 1'b1);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110 || rsp_result !== 32'd0) begin
            errors++;
            $display("FAIL div0_rsp: got vld=%0d err=%0d to=%0d res=%0d, required 1 1 0 0",
                     rsp_valid, rsp_err, rsp_timeout, rsp_result);
        end
        @(posedge clk); #1;
        wait_drain(20);
        checks++;
        if (start_cnt !== s0) begin
            errors++;
            $display("FAIL div0_no_start: got %0d pulses, required 0", start_cnt - s0);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        model_lat = 3;
        rsp_ready = 1'b0;
        send(32'd100, 32'd7, 1'b1);
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!rsp_valid) begin
            errors++;
            $display("FAIL bp_valid_wait: got rsp_valid=0, required 1");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'd2 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got vld=%0d res=%0d rdy=%0d, required 1 2 0",
                         i, rsp_valid, rsp_result, req_ready);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (fsm_state !== IDLE || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got st=%0d rdy=%0d, required 0 1", fsm_state, req_ready);
        end
        wait_drain(5);
    endtask

    task automatic test_timeout();
        int waits = 0;
        logic [33:0] got = '0;
        rsp_ready = 1'b1;
        model_never_done = 1'b1;
        send(32'd50, 32'd3, 1'b1);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (fsm_state == WAIT) waits++;
            if (rsp_valid) begin
                got = {rsp_err, rsp_timeout, rsp_result};
                break;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (waits !== 8) begin
            errors++;
            $display("FAIL timeout_wait_cycles: got %0d, required 8", waits);
        end
        checks++;
        if (got !== {2'b11, 32'd0}) begin
            errors++;
            $display("FAIL timeout_rsp: got err=%0d to=%0d res=%0d, required 1 1 0", got[33], got[32], got[31:0]);
        end
        wait_drain(20);
        model_never_done = 1'b0;
    endtask

    task automatic test_stale_done();
        logic [31:0] res = 32'hffff_ffff;
        rsp_ready = 1'b1;
        model_lat = 3;
        force_done = 1'b1;
        send(32'd9, 32'd4, 1'b1);
        @(posedge clk); #1;
        force_done = 1'b0;
        checks++;
        if (fsm_state !== WAIT) begin
            errors++;
            $display("FAIL stale_issue: got st=%0d after ISSUE, required %0d", fsm_state, WAIT);
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                res = rsp_result;
                break;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (res !== 32'd1) begin
            errors++;
            $display("FAIL stale_result: got %0d, required 1", res);
        end
        wait_drain(20);
    endtask

    task automatic test_reset_midop();
        bit saw = 1'b0;
        rsp_ready = 1'b1;
        model_lat = 20;
        send(32'd77, 32'd5, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (fsm_state !== WAIT) begin
            errors++;
            $display("FAIL midop_pre: got st=%0d, required %0d", fsm_state, WAIT);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (fsm_state !== IDLE || {req_ready, rsp_valid, mod_start} !== 3'b100) begin
            errors++;
            $display("FAIL midop_reset: got st=%0d rdy=%0d vld=%0d start=%0d, required 0 1 0 0",
                     fsm_state, req_ready, rsp_valid, mod_start);
        end
        rst = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
        end
        @(posedge clk); #1;
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL midop_no_rsp: got rsp_valid=1 after reset, required 0");
        end
        model_lat = 4;
        send(32'd10, 32'd3, 1'b1);
        wait_drain(30);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i == 3) ? 32'd0 : 32'($urandom_range(1, 1000));
            model_lat = $urandom_range(1, 5);
            send(a, b, 1'b1);
        end
        wait_drain(200);
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_div0();
        test_backpressure();
        test_timeout();
        test_stale_done();
        test_reset_midop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
